booth_divider: RTL and testbench

//  Sequential signed N-bit integer divider; inverse-operation companion to booth_multiplier.

---
 rtl/div_pkg.sv | 19 +
 rtl/carry_lookahead_adder.sv | 25 ++
 rtl/booth_divider.sv | 136 +++++++++++++
 tb/tb_booth_divider.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
// abs_n is sized by DIV_N, so the divider's N must match it.
package div_pkg;
   localparam int DIV_N = 4;

   typedef enum logic [2:0] {
      IDLE,
      INITIALIZE,
      SHIFT_SUB,
      TEST_SET,
      SIGN_FIX,
      DONE
   } div_state_t;

   // Unsigned magnitude of a two's-complement value; the most negative value maps to 2^(N-1).
   function automatic logic [DIV_N-1:0] abs_n(input logic [DIV_N-1:0] v);
      return v[DIV_N-1] ? (~v + 1'b1) : v;
   endfunction
endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit carry-lookahead adder (generate/propagate form); shared with booth_multiplier.
// The final carry is not produced because no client uses it.
module carry_lookahead_adder #(
   parameter int N = 5
) (
   input  logic [N-1:0] operand1,
   input  logic [N-1:0] operand2,
   input  logic         cin,
   output logic [N-1:0] sum
);
   logic [N-1:0] gen;
   logic [N-1:0] prop;
   logic [N-1:0] carry;

   always_comb begin
      gen   = operand1 & operand2;
      prop  = operand1 ^ operand2;
      carry = '0;
      carry[0] = cin;
      for (int i = 1; i < N; i++) begin
         carry[i] = gen[i-1] | (prop[i-1] & carry[i-1]);
      end
      sum = prop ^ carry;
   end
endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring shift/subtract on magnitudes, then sign correction.
// Quotient truncates toward zero; remainder follows the dividend's sign.
//
//   state      | meaning
//   IDLE       | waiting for start; operands captured on acceptance
//   INITIALIZE | load magnitudes and signs; divide-by-zero short-cut
//   SHIFT_SUB  | shift {A,Q} left, register A and ~M into the adder
//   TEST_SET   | keep A-M if non-negative and set Q[0], else restore
//   SIGN_FIX   | apply signs to quotient and remainder
//   DONE       | one-cycle done pulse
module booth_divider
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero,
   output logic         busy,
   output logic         done
);
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (N != DIV_N) begin : g_width_check
      $error("booth_divider N must equal div_pkg::DIV_N");
   end

   div_state_t     state;
   logic [N:0]     a_r;
   logic [N-1:0]   q_r;
   logic [N-1:0]   m_r;
   logic           q_neg;
   logic           r_neg;
   logic [CW-1:0]  count;
   logic [N-1:0]   dvd_r;
   logic [N-1:0]   dvs_r;
   logic [N:0]     op1_r;
   logic [N:0]     op2_r;
   logic [N:0]     sum;
   logic [2*N:0]   aq_sh;

   assign aq_sh = {a_r, q_r} << 1;

   carry_lookahead_adder #(.N(N + 1)) u_sub (
      .operand1 (op1_r),
      .operand2 (op2_r),
      .cin      (1'b1),
      .sum      (sum)
   );

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         a_r         <= '0;
         q_r         <= '0;
         m_r         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         dvd_r       <= '0;
         dvs_r       <= '0;
         op1_r       <= '0;
         op2_r       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dvd_r <= dividend;
                  dvs_r <= divisor;
                  state <= INITIALIZE;
               end
            end
            INITIALIZE: begin
               a_r   <= '0;
               q_r   <= abs_n(dvd_r);
               m_r   <= abs_n(dvs_r);
               q_neg <= dvd_r[N-1] ^ dvs_r[N-1];
               r_neg <= dvd_r[N-1];
               count <= '0;
               if (dvs_r == '0) begin
                  quotient    <= '1;
                  remainder   <= dvd_r;
                  div_by_zero <= 1'b1;
                  state       <= DONE;
               end else begin
                  div_by_zero <= 1'b0;
                  state       <= SHIFT_SUB;
               end
            end
            SHIFT_SUB: begin
               a_r   <= aq_sh[2*N:N];
               q_r   <= aq_sh[N-1:0];
               op1_r <= aq_sh[2*N:N];
               op2_r <= ~{1'b0, m_r};
               state <= TEST_SET;
            end
            TEST_SET: begin
               // sum[N] clear means the trial subtraction did not go negative
               if (!sum[N]) begin
                  a_r    <= sum;
                  q_r[0] <= 1'b1;
               end else begin
                  q_r[0] <= 1'b0;
               end
               count <= count + 1'b1;
               state <= (count == LAST) ? SIGN_FIX : SHIFT_SUB;
            end
            SIGN_FIX: begin
               quotient  <= q_neg ? (~q_r + 1'b1) : q_r;
               remainder <= r_neg ? (~a_r[N-1:0] + 1'b1) : a_r[N-1:0];
               state     <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_booth_divider.sv
// Directed bench for booth_divider (N=4) with hand-computed quotients, remainders and latencies.
module tb_booth_divider;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;
   logic       busy;
   logic       done;

   int total = 0;
   int bad = 0;

   booth_divider #(.N(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sx(input logic [3:0] v);
      return int'($signed(v));
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issue one division and check latency, busy window, and results.
   task automatic do_div(input int dvd, input int dvs, input int eq, input int er,
                         input int edz, input int elat);
      int    lat;
      bit    busy_ok;
      string id;
      id = $sformatf("%0d/%0d", dvd, dvs);
      dividend = 4'(dvd);
      divisor  = 4'(dvs);
      start    = 1'b1;
      step();
      start    = 1'b0;
      lat      = -1;
      busy_ok  = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
         step();
      end
      chk({id, " latency"}, lat, elat);
      chk({id, " busy"}, int'(busy_ok), 1);
      chk({id, " quotient"}, sx(quotient), eq);
      chk({id, " remainder"}, sx(remainder), er);
      chk({id, " div_by_zero"}, int'(div_by_zero), edz);
      step();
      chk({id, " idle after done"}, int'({busy, done}), 0);
   endtask

   initial begin
      int dones;
      int lat;
      step();
      step();
      chk("reset quotient", sx(quotient), 0);
      chk("reset remainder", sx(remainder), 0);
      chk("reset flags", int'({div_by_zero, busy, done}), 0);
      reset = 1'b0;
      step();

      do_div( 7,  2,  3,  1, 0, 11);
      do_div(-7,  2, -3, -1, 0, 11);
      do_div( 7, -2, -3,  1, 0, 11);
      do_div(-8, -1, -8,  0, 0, 11);
      do_div(-8,  3, -2, -2, 0, 11);
      do_div( 3,  5,  0,  3, 0, 11);
      do_div(-1, -8,  0, -1, 0, 11);
      do_div(-5,  2, -2, -1, 0, 11);
      do_div( 7,  7,  1,  0, 0, 11);
      do_div( 5,  0, -1,  5, 1, 2);
      do_div( 6,  3,  2,  0, 0, 11);

      // start held and operands scrambled every cycle of an operation
      dividend = 4'd7;
      divisor  = 4'd2;
      start    = 1'b1;
      step();
      dones = 0;
      lat   = -1;
      for (int k = 1; k <= 40; k++) begin
         dividend = 4'(k * 3);
         divisor  = 4'(k + 5);
         if (done) begin
            dones++;
            lat   = k;
            start = 1'b0;
            chk("busy-pulse quotient", sx(quotient), 3);
            chk("busy-pulse remainder", sx(remainder), 1);
            break;
         end
         step();
      end
      chk("busy-pulse latency", lat, 11);
      for (int k = 0; k < 15; k++) begin
         step();
         if (done) dones++;
      end
      chk("busy-pulse done count", dones, 1);
      do_div(-6, 4, -1, -2, 0, 11);

      // reset during an operation
      dividend = 4'd7;
      divisor  = 4'd2;
      start    = 1'b1;
      step();
      start = 1'b0;
      dones = 0;
      for (int k = 1; k < 5; k++) begin
         if (done) dones++;
         step();
      end
      reset = 1'b1;
      step();
      chk("mid-reset quotient", sx(quotient), 0);
      chk("mid-reset remainder", sx(remainder), 0);
      chk("mid-reset flags", int'({div_by_zero, busy, done}), 0);
      reset = 1'b0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (done) dones++;
      end
      chk("mid-reset no done", dones, 0);
      do_div(6, 4, 1, 2, 0, 11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
